// File: rtl/chip4_pneumatic_sequencer_pkg.sv
// Shared definitions for the ChIP4 control-side blocks: sequencer states,
// the peristaltic pump phase table and valve polarity constants.
package chip4_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    OPEN     = 3'd1,
    PUMP     = 3'd2,
    CLOSE    = 3'd3,
    INCUBATE = 3'd4,
    DONE     = 3'd5
  } seqState_e;

  // A pressurized pneumatic line closes its valve.
  localparam logic VALVE_CLOSED = 1'b1;

  localparam int INLET_COUNT = 5;
  localparam int PHASE_COUNT = 6;

  // {pump1,pump2,pump3} per phase; entry 0 is the first phase of a stroke.
  localparam logic [PHASE_COUNT-1:0][2:0] PUMP_PATTERN = {
    3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101
  };

  // Out-of-range phase indices fall back to all valves closed.
  function automatic logic [2:0] pumpPattern(input logic [2:0] phase);
    logic [2:0] pattern;
    pattern = {3{VALVE_CLOSED}};
    if (phase < 3'(PHASE_COUNT)) pattern = PUMP_PATTERN[phase];
    return pattern;
  endfunction

endpackage

// File: rtl/chip4_pneumatic_sequencer_if.sv
// Request/status and pneumatic valve bundle between a host controller and
// the ChIP4 pneumatic sequencer.
interface chip4_pneumatic_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [2:0]       inlet_sel;
  logic [15:0]      pump_strokes;
  logic [CNT_W-1:0] incubate_cycles;
  logic             abort;
  logic             busy;
  logic             done;
  logic             error;
  logic [4:0]       inlet_ctrl;
  logic             prep_inlet_ctrl;
  logic             stage_inlet_ctrl;
  logic             pump1;
  logic             pump2;
  logic             pump3;

  modport master (
    output start, inlet_sel, pump_strokes, incubate_cycles, abort,
    input  busy, done, error, inlet_ctrl, prep_inlet_ctrl, stage_inlet_ctrl,
           pump1, pump2, pump3
  );

  modport slave (
    input  start, inlet_sel, pump_strokes, incubate_cycles, abort,
    output busy, done, error, inlet_ctrl, prep_inlet_ctrl, stage_inlet_ctrl,
           pump1, pump2, pump3
  );
endinterface

// File: rtl/chip4_pneumatic_sequencer_pump.sv
// Three-valve peristaltic pump driver: steps through the six-phase pattern,
// holding each phase PHASE_CYCLES cycles, for a given number of strokes.
module peristaltic_pump_driver
  import chip4_ctrl_pkg::*;
#(
  parameter int PHASE_CYCLES = 1000,
  parameter int CNT_W        = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic [15:0] strokes_i,
  output logic [2:0]  pump_o,
  output logic        strokeDone_o
);

  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_ONE    = CNT_W'(1);

  logic [CNT_W-1:0] div_q, div_d;
  logic [2:0]       phase_q, phase_d;
  logic [15:0]      stroke_q, stroke_d;
  logic             lastDiv, lastPhase, lastStroke;

  assign lastDiv      = (div_q == PHASE_LAST);
  assign lastPhase    = (phase_q == 3'(PHASE_COUNT - 1));
  assign lastStroke   = (stroke_q == (strokes_i - 16'd1));
  assign strokeDone_o = enable_i && lastDiv && lastPhase && lastStroke;
  assign pump_o       = enable_i ? pumpPattern(phase_q) : {3{VALVE_CLOSED}};

  // Advance divider, phase and stroke counters; restart from phase 0 whenever idle.
  always_comb begin
    div_d    = div_q + DIV_ONE;
    phase_d  = phase_q;
    stroke_d = stroke_q;
    if (!enable_i || strokeDone_o) begin
      div_d    = '0;
      phase_d  = '0;
      stroke_d = '0;
    end else if (lastDiv) begin
      div_d = '0;
      if (lastPhase) begin
        phase_d  = '0;
        stroke_d = stroke_q + 16'd1;
      end else begin
        phase_d = phase_q + 3'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      phase_q  <= '0;
      stroke_q <= '0;
    end else begin
      div_q    <= div_d;
      phase_q  <= phase_d;
      stroke_q <= stroke_d;
    end
  end

endmodule

// File: rtl/chip4_pneumatic_sequencer.sv
// ChIP4 aliquot sequencer: opens the selected reagent path, pumps N strokes,
// closes, incubates, then reports done. Every output is registered and all
// valves are closed whenever the block is idle, aborted or in reset.
module chip4_pneumatic_sequencer
  import chip4_ctrl_pkg::*;
#(
  parameter int PHASE_CYCLES  = 1000,
  parameter int SETTLE_CYCLES = 500,
  parameter int CNT_W         = 32
) (
  input logic clk,
  input logic rst,
  chip4_pneumatic_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  seqState_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reject_q, reject_d;
  logic [2:0]       sel_q;
  logic [15:0]      strokes_q;
  logic [CNT_W-1:0] incubate_q;

  logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [4:0]       inlet_q, inlet_d;
  logic             prep_q, prep_d, stage_q, stage_d;
  logic [2:0]       pump_q, pump_d;

  logic             startSeen, selValid, abortNow, pumpEnable, strokeDone;
  logic [2:0]       drvPump;

  // The busy output lags the state by a cycle, so both must be idle before a
  // start is considered; a simultaneous abort silently drops the request.
  assign startSeen  = bus.start && (state_q == IDLE) && !busy_q && !bus.abort;
  assign selValid   = (bus.inlet_sel >= 3'd1) && (bus.inlet_sel <= 3'(INLET_COUNT));
  assign abortNow   = bus.abort && (state_q != IDLE);
  assign pumpEnable = (state_q == PUMP);

  peristaltic_pump_driver #(
    .PHASE_CYCLES (PHASE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_pump (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (pumpEnable),
    .strokes_i    (strokes_q),
    .pump_o       (drvPump),
    .strokeDone_o (strokeDone)
  );

  // State register, cycle counter and run parameters latched on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      reject_q   <= 1'b0;
      sel_q      <= '0;
      strokes_q  <= '0;
      incubate_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reject_q <= reject_d;
      if (startSeen && selValid) begin
        sel_q      <= bus.inlet_sel;
        strokes_q  <= bus.pump_strokes;
        incubate_q <= bus.incubate_cycles;
      end
    end
  end

  // Next-state logic: settle/incubate timing and skipping empty pump or incubate phases.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reject_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (startSeen) begin
          if (selValid) state_d = OPEN;
          else          reject_d = 1'b1;
        end
      end
      OPEN: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = (strokes_q == 16'd0) ? CLOSE : PUMP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PUMP: begin
        if (strokeDone) state_d = CLOSE;
      end
      CLOSE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = (incubate_q == '0) ? DONE : INCUBATE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      INCUBATE: begin
        if (cnt_q == (incubate_q - CNT_ONE)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abortNow) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Output decode from the current state; an abort forces the safe state immediately.
  always_comb begin
    busy_d  = (state_q != IDLE);
    done_d  = (state_q == DONE);
    error_d = reject_q;
    inlet_d = {INLET_COUNT{VALVE_CLOSED}};
    prep_d  = VALVE_CLOSED;
    stage_d = VALVE_CLOSED;
    pump_d  = {3{VALVE_CLOSED}};
    if ((state_q == OPEN) || (state_q == PUMP)) begin
      for (int i = 0; i < INLET_COUNT; i++) begin
        if (sel_q == 3'(i + 1)) inlet_d[i] = ~VALVE_CLOSED;
      end
      prep_d  = ~VALVE_CLOSED;
      stage_d = ~VALVE_CLOSED;
    end
    if (state_q == PUMP) pump_d = drvPump;
    if (abortNow) begin
      busy_d  = 1'b0;
      done_d  = 1'b0;
      error_d = 1'b1;
      inlet_d = {INLET_COUNT{VALVE_CLOSED}};
      prep_d  = VALVE_CLOSED;
      stage_d = VALVE_CLOSED;
      pump_d  = {3{VALVE_CLOSED}};
    end
  end

  // Output registers; reset closes every valve.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      inlet_q <= {INLET_COUNT{VALVE_CLOSED}};
      prep_q  <= VALVE_CLOSED;
      stage_q <= VALVE_CLOSED;
      pump_q  <= {3{VALVE_CLOSED}};
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      inlet_q <= inlet_d;
      prep_q  <= prep_d;
      stage_q <= stage_d;
      pump_q  <= pump_d;
    end
  end

  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.error            = error_q;
  assign bus.inlet_ctrl       = inlet_q;
  assign bus.prep_inlet_ctrl  = prep_q;
  assign bus.stage_inlet_ctrl = stage_q;
  assign bus.pump1            = pump_q[2];
  assign bus.pump2            = pump_q[1];
  assign bus.pump3            = pump_q[0];

endmodule

// File: tb/tb_chip4_pneumatic_sequencer.sv
// Bench for the ChIP4 pneumatic sequencer with short phase/settle times.
// Expected per-cycle output traces are queued when a request is driven and
// popped one per clock as the DUT produces output.
module tb_chip4_pneumatic_sequencer;

  localparam int PH = 2;
  localparam int ST = 3;
  localparam int CW = 32;

  // Packed view: {busy, done, error, inlet[4:0], prep, stage, pump1..3}
  localparam logic [12:0] IDLE_VEC = {3'b000, 5'b11111, 2'b11, 3'b111};

  typedef struct {
    string       name;
    logic [12:0] vec;
  } exp_t;

  typedef struct {
    string       name;
    logic [2:0]  sel;
    logic [15:0] strokes;
    logic [31:0] incubate;
    bit          accept;
    logic [4:0]  expInlet;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  exp_t        expQ[$];
  logic [12:0] trace[$];
  vec_t        table_v[8];
  int          compared   = 0;
  int          mismatched = 0;

  chip4_pneumatic_sequencer_if #(.CNT_W(CW)) bus();

  chip4_pneumatic_sequencer #(
    .PHASE_CYCLES  (PH),
    .SETTLE_CYCLES (ST),
    .CNT_W         (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Safety net so the bench always ends.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: got no completion, expected finish within bound");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [12:0] mk(input bit busy, input bit done, input bit err,
                                     input logic [4:0] inlet, input bit pathOpen,
                                     input logic [2:0] pump);
    return {busy, done, err, inlet, (pathOpen ? 2'b00 : 2'b11), pump};
  endfunction

  function automatic logic [2:0] patternFor(input int p);
    case (p)
      0:       return 3'b101;
      1:       return 3'b100;
      2:       return 3'b110;
      3:       return 3'b010;
      4:       return 3'b011;
      default: return 3'b001;
    endcase
  endfunction

  // Expected trace starting with the sample taken right after the start edge.
  task automatic buildRun(input logic [15:0] strokes, input logic [31:0] inc,
                          input bit accept, input logic [4:0] expInlet);
    trace.delete();
    trace.push_back(IDLE_VEC);
    if (!accept) begin
      trace.push_back(mk(0, 0, 1, 5'b11111, 0, 3'b111));
    end else begin
      repeat (ST) trace.push_back(mk(1, 0, 0, expInlet, 1, 3'b111));
      for (int k = 0; k < 6 * PH * int'(strokes); k++)
        trace.push_back(mk(1, 0, 0, expInlet, 1, patternFor((k / PH) % 6)));
      repeat (ST) trace.push_back(mk(1, 0, 0, 5'b11111, 0, 3'b111));
      for (int k = 0; k < int'(inc); k++)
        trace.push_back(mk(1, 0, 0, 5'b11111, 0, 3'b111));
      trace.push_back(mk(1, 1, 0, 5'b11111, 0, 3'b111));
    end
    trace.push_back(IDLE_VEC);
    trace.push_back(IDLE_VEC);
  endtask

  task automatic pushTrace(input string name, input int count);
    exp_t e;
    for (int i = 0; i < trace.size(); i++) begin
      if (count >= 0 && i >= count) break;
      e.name = $sformatf("%s[%0d]", name, i);
      e.vec  = trace[i];
      expQ.push_back(e);
    end
  endtask

  task automatic pushOne(input string name, input logic [12:0] v);
    exp_t e;
    e.name = name;
    e.vec  = v;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [12:0] expVec);
    logic [12:0] act;
    act = {bus.busy, bus.done, bus.error, bus.inlet_ctrl, bus.prep_inlet_ctrl,
           bus.stage_inlet_ctrl, bus.pump1, bus.pump2, bus.pump3};
    compared++;
    if (act !== expVec) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, expVec);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e.name, e.vec);
    end
  endtask

  task automatic drain();
    while (expQ.size() > 0) step();
  endtask

  task automatic applyStimulus(input logic [2:0] sel, input logic [15:0] strokes,
                               input logic [31:0] inc);
    bus.inlet_sel       = sel;
    bus.pump_strokes    = strokes;
    bus.incubate_cycles = inc;
    bus.start           = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    table_v[0] = '{"sel2_s2_i5", 3'd2, 16'd2, 32'd5, 1'b1, 5'b11101};
    table_v[1] = '{"sel1_s0_i0", 3'd1, 16'd0, 32'd0, 1'b1, 5'b11110};
    table_v[2] = '{"sel5_s1_i3", 3'd5, 16'd1, 32'd3, 1'b1, 5'b01111};
    table_v[3] = '{"sel0_rej",   3'd0, 16'd1, 32'd1, 1'b0, 5'b11111};
    table_v[4] = '{"sel6_rej",   3'd6, 16'd1, 32'd1, 1'b0, 5'b11111};
    table_v[5] = '{"sel7_rej",   3'd7, 16'd0, 32'd0, 1'b0, 5'b11111};
    table_v[6] = '{"sel4_s0_i2", 3'd4, 16'd0, 32'd2, 1'b1, 5'b10111};
    table_v[7] = '{"sel3_s1_i0", 3'd3, 16'd1, 32'd0, 1'b1, 5'b11011};

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.inlet_sel = '0;
    bus.pump_strokes = '0;
    bus.incubate_cycles = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset", IDLE_VEC);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      buildRun(table_v[i].strokes, table_v[i].incubate, table_v[i].accept, table_v[i].expInlet);
      pushTrace(table_v[i].name, -1);
      applyStimulus(table_v[i].sel, table_v[i].strokes, table_v[i].incubate);
      drain();
    end

    // Reset in the middle of pumping.
    buildRun(16'd4, 32'd10, 1'b1, 5'b11011);
    pushTrace("rstPump", 1 + ST + 10);
    applyStimulus(3'd3, 16'd4, 32'd10);
    drain();
    rst = 1'b1;
    pushOne("rstPump.reset", IDLE_VEC);
    step();
    rst = 1'b0;
    pushOne("rstPump.after0", IDLE_VEC);
    pushOne("rstPump.after1", IDLE_VEC);
    drain();

    // Abort while incubating, then a normal run.
    buildRun(16'd1, 32'd20, 1'b1, 5'b11110);
    pushTrace("abortInc", 1 + ST + 6 * PH + ST + 5);
    applyStimulus(3'd1, 16'd1, 32'd20);
    drain();
    bus.abort = 1'b1;
    pushOne("abortInc.abort", mk(0, 0, 1, 5'b11111, 0, 3'b111));
    step();
    bus.abort = 1'b0;
    for (int i = 0; i < 25; i++) pushOne($sformatf("abortInc.after%0d", i), IDLE_VEC);
    drain();
    buildRun(16'd1, 32'd2, 1'b1, 5'b10111);
    pushTrace("postAbort", -1);
    applyStimulus(3'd4, 16'd1, 32'd2);
    drain();

    // Start re-requested with another inlet while busy.
    buildRun(16'd2, 32'd5, 1'b1, 5'b11101);
    pushTrace("busyStart", -1);
    applyStimulus(3'd2, 16'd2, 32'd5);
    repeat (5) step();
    bus.inlet_sel = 3'd5;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (20) step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    drain();

    // Abort together with start in IDLE: nothing happens.
    bus.abort = 1'b1;
    for (int i = 0; i < 3; i++) pushOne($sformatf("abortStartIdle%0d", i), IDLE_VEC);
    applyStimulus(3'd2, 16'd1, 32'd0);
    bus.abort = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
